case_7_sdiv_10s_10s_10_seq: RTL and testbench

//  Sequential signed divider: the inverse operator of the case_7 signed 10x10 multiplier.

---
 rtl/case_7_sdiv_10s_10s_10_seq.sv | 151 +++++++++++++++
 tb/tb_case_7_sdiv_10s_10s_10_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/case_7_sdiv_10s_10s_10_seq.sv
// Sequential signed divider with start/done handshake: C-style truncating quotient and
// dividend-signed remainder, one quotient bit per cycle over a non-restoring datapath.
module case_7_sdiv_10s_10s_10_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_width_check
    $error("sdiv instance %0d: DATA_WIDTH must be 2..32", ID);
  end

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;     // dividend magnitude, shifted out MSB first
  logic [W-1:0]    d_q, d_d;     // divisor magnitude
  logic [W+1:0]    r_q, r_d;     // signed partial remainder
  logic [W-1:0]    q_q, q_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic            dz_q, dz_d, ov_q, ov_d;
  logic [W-1:0]    quot_q, quot_d, rem_q, rem_d;
  logic            dzf_q, dzf_d, ovf_q, ovf_d;

  logic            accept;
  logic [W-1:0]    din0_abs, din1_abs;
  logic [W+1:0]    r_sh, r_nx;
  logic [W-1:0]    r_fix;

  // A W-bit unsigned magnitude already holds |MIN| = 2^(W-1) exactly.
  assign din0_abs = din0[W-1] ? (~din0 + W'(1)) : din0;
  assign din1_abs = din1[W-1] ? (~din1 + W'(1)) : din1;

  assign accept = ap_start && ((state_q == StIdle) || (state_q == StDone));

  assign r_sh  = {r_q[W:0], a_q[W-1]};
  assign r_nx  = r_q[W+1] ? (r_sh + {2'b00, d_q}) : (r_sh - {2'b00, d_q});
  // Final non-restoring correction; the corrected remainder is below the divisor.
  assign r_fix = r_q[W-1:0] + (r_q[W+1] ? d_q : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzf_d   = dzf_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: ;
      StCalc: begin
        a_d   = a_q << 1;
        r_d   = r_nx;
        q_d   = {q_q[W-2:0], ~r_nx[W+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        quot_d  = dz_q ? '1 : ((sa_q ^ sb_q) ? (~q_q + W'(1)) : q_q);
        // With a zero divisor r_fix equals |din0|, so this restores din0.
        rem_d   = sa_q ? (~r_fix + W'(1)) : r_fix;
        dzf_d   = dz_q;
        ovf_d   = ov_q;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d     = din0_abs;
      d_d     = din1_abs;
      r_d     = '0;
      q_d     = '0;
      sa_d    = din0[W-1];
      sb_d    = din1[W-1];
      dz_d    = (din1 == '0);
      ov_d    = (din0 == {1'b1, {(W-1){1'b0}}}) && (&din1);
      cnt_d   = '0;
      state_d = StCalc;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzf_q   <= dzf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ap_idle     = (state_q == StIdle);
  assign ap_done     = (state_q == StDone);
  assign ap_ready    = (state_q == StDone);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dzf_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_case_7_sdiv_10s_10s_10_seq.sv
// Directed bench for the 10-bit sequential signed divider: latency, sign matrix, corners,
// back-to-back handshake, mid-operation reset, plus a short C-model sweep.
module tb_case_7_sdiv_10s_10s_10_seq;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic       ap_start;
  logic       ap_idle, ap_ready, ap_done;
  logic [9:0] din0, din1;
  logic [9:0] quot, rem;
  logic       div_by_zero, overflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] prev_q = '0;
  logic [9:0] prev_r = '0;

  always #5 ap_clk = ~ap_clk;

  case_7_sdiv_10s_10s_10_seq #(
    .ID         (1),
    .DATA_WIDTH (10)
  ) u_dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accept edge until ap_done; gives up after 40.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge ap_clk);
      #1;
      n++;
      if (n == 5) begin
        check({tag, "_busy_hold"}, {12'b0, quot, rem}, {12'b0, prev_q, prev_r});
        check({tag, "_busy_idle"}, {31'b0, ap_idle}, 32'd0);
      end
      if (ap_done) break;
    end
  endtask

  task automatic check_result(input string tag, input int q, input int r, input int dz,
                              input int ov);
    check({tag, "_quot"}, {22'b0, quot}, {22'b0, q[9:0]});
    check({tag, "_rem"}, {22'b0, rem}, {22'b0, r[9:0]});
    check({tag, "_dz"}, {31'b0, div_by_zero}, dz);
    check({tag, "_ov"}, {31'b0, overflow}, ov);
    check({tag, "_ready"}, {31'b0, ap_ready}, 32'd1);
    prev_q = q[9:0];
    prev_r = r[9:0];
  endtask

  // Single op from IDLE; operands are scrambled right after the accept edge.
  task automatic run_op(input string tag, input int a, input int b, input int q, input int r,
                        input int dz, input int ov);
    int n;
    din0     = a[9:0];
    din1     = b[9:0];
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0     = 10'($urandom);
    din1     = 10'($urandom);
    wait_done(tag, n);
    check({tag, "_latency"}, n, 32'd11);
    check_result(tag, q, r, dz, ov);
    @(posedge ap_clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, ap_done}, 32'd0);
    check({tag, "_back_idle"}, {31'b0, ap_idle}, 32'd1);
  endtask

  int ta[4] = '{50, -77, 9, 123};
  int tb[4] = '{3, 5, -2, 0};
  int eq[3] = '{16, -15, -4};
  int er[3] = '{2, -2, 1};

  initial begin
    int n;
    int n_done;
    int a, b, q, r;

    ap_rst_n = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_idle", {31'b0, ap_idle}, 32'd1);
    check("rst_ready", {31'b0, ap_ready}, 32'd0);
    check("rst_done", {31'b0, ap_done}, 32'd0);
    check("rst_quot_rem", {12'b0, quot, rem}, 32'd0);
    check("rst_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Basic op and sign matrix
    run_op("t1", 100, 7, 14, 2, 0, 0);
    run_op("t2_nn", -100, 7, -14, -2, 0, 0);
    run_op("t2_pn", 100, -7, -14, 2, 0, 0);
    run_op("t2_mm", -100, -7, 14, -2, 0, 0);
    run_op("t2_small", 5, 9, 0, 5, 0, 0);

    // Corners
    run_op("t3_ovf", -512, -1, -512, 0, 0, 1);
    run_op("t3_dz", 37, 0, -1, 37, 1, 0);
    run_op("t3_min_1", -512, 1, -512, 0, 0, 0);
    run_op("t3_dz_min", -512, 0, -1, -512, 1, 0);
    run_op("t3_min_min", -512, -512, 1, 0, 0, 0);
    run_op("t3_max_2", 511, 2, 255, 1, 0, 0);
    run_op("t3_1_min", 1, -512, 0, 1, 0, 0);

    // Back-to-back with ap_start held; next operands appear during CALC
    din0     = ta[0][9:0];
    din1     = tb[0][9:0];
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    din0 = ta[1][9:0];
    din1 = tb[1][9:0];
    for (int i = 0; i < 3; i++) begin
      wait_done($sformatf("t4_%0d", i), n);
      check($sformatf("t4_%0d_period", i), n + 1, 32'd12);
      check_result($sformatf("t4_%0d", i), eq[i], er[i], 0, 0);
      if (i < 2) begin
        @(posedge ap_clk);
        #1;
        check($sformatf("t4_%0d_no_idle", i), {31'b0, ap_idle}, 32'd0);
        din0 = ta[i+2][9:0];
        din1 = tb[i+2][9:0];
        if (i == 1) ap_start = 1'b0;
      end
    end
    @(posedge ap_clk);
    #1;
    check("t4_final_idle", {31'b0, ap_idle}, 32'd1);

    // Reset in the middle of CALC
    din0     = 10'd100;
    din1     = 10'd7;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (5) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("t5_idle", {31'b0, ap_idle}, 32'd1);
    check("t5_quot_rem", {12'b0, quot, rem}, 32'd0);
    check("t5_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    n_done   = 0;
    repeat (20) begin
      @(posedge ap_clk);
      #1;
      if (ap_done) n_done++;
    end
    check("t5_no_done", n_done, 32'd0);
    prev_q = '0;
    prev_r = '0;
    run_op("t5_after", -9, 4, -2, -1, 0, 0);

    // Short sweep against C division semantics
    for (int i = 0; i < 64; i++) begin
      a = int'($urandom_range(0, 1023)) - 512;
      b = (i % 9 == 0) ? 0 : int'($urandom_range(0, 1023)) - 512;
      if (b == 0) begin
        q = -1;
        r = a;
      end else if (a == -512 && b == -1) begin
        q = -512;
        r = 0;
      end else begin
        q = a / b;
        r = a % b;
      end
      run_op($sformatf("t6_%0d", i), a, b, q, r, (b == 0) ? 1 : 0,
             (a == -512 && b == -1) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
